// File: rtl/nbit_run_counter.sv
// ----------------------------------------------------------------------------
// nbit_run_counter
//
// Parametrised start/stop event counter with up/down direction, parallel
// load, programmable up-count terminal, clock prescaler and wrap/halt
// behaviour at terminal count.
//
// Parameters
//   WIDTH     counter width in bits (>= 1)
//   PRESCALE  RUN-state clocks per count step (>= 1)
//   WRAP      1 = wrap at terminal count and keep running,
//             0 = freeze at terminal count and enter HALT
//
// Ports
//   Clock        in   system clock, rising edge active
//   Reset        in   asynchronous active-high reset
//   start        in   begin/resume counting (only from IDLE)
//   stop         in   pause counting, value held (from RUN or HALT)
//   up_down      in   1 = count up, 0 = count down
//   load         in   synchronous parallel load, returns to IDLE
//   load_value   in   value written by load
//   limit        in   up-count terminal value (down terminal is 0)
//   clear_flag   in   clears blow_up
//   Counter_Out  out  current count
//   running      out  high while in RUN
//   tc_pulse     out  one-cycle pulse after each terminal-count step
//   blow_up      out  sticky terminal-count flag
// ----------------------------------------------------------------------------
module nbit_run_counter #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1,
   parameter int WRAP     = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             start,
   input  logic             stop,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] limit,
   input  logic             clear_flag,
   output logic [WIDTH-1:0] Counter_Out,
   output logic             running,
   output logic             tc_pulse,
   output logic             blow_up
);

   // Prescaler needs at least one bit even when PRESCALE == 1.
   localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t           r_state;
   logic [PW-1:0]    r_presc;
   logic [WIDTH-1:0] r_count;
   logic             r_running;
   logic             r_tc;
   logic             r_blow;

   // Terminal test uses >= so a value loaded above the limit terminates
   // on its first up step instead of running round the full range.
   logic w_terminal;
   assign w_terminal = up_down ? (r_count >= limit) : (r_count == '0);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_presc   <= '0;
         r_count   <= '0;
         r_running <= 1'b0;
         r_tc      <= 1'b0;
         r_blow    <= 1'b0;
      end else begin
         r_tc <= 1'b0;

         // Placed before the step logic so a terminal step on the same
         // edge overrides the clear.
         if (clear_flag) begin
            r_blow <= 1'b0;
         end

         if (load) begin
            r_count   <= load_value;
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_presc   <= '0;
         end else if (stop) begin
            if (r_state != S_IDLE) begin
               r_state   <= S_IDLE;
               r_running <= 1'b0;
               r_presc   <= '0;
            end
         end else if (start && (r_state == S_IDLE)) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_presc   <= '0;
         end else if (r_state == S_RUN) begin
            if (r_presc == PS_LAST) begin
               r_presc <= '0;
               if (w_terminal) begin
                  r_tc   <= 1'b1;
                  r_blow <= 1'b1;
                  if (WRAP != 0) begin
                     r_count <= up_down ? '0 : limit;
                  end else begin
                     r_state   <= S_HALT;
                     r_running <= 1'b0;
                  end
               end else begin
                  r_count <= up_down ? (r_count + 1'b1) : (r_count - 1'b1);
               end
            end else begin
               r_presc <= r_presc + 1'b1;
            end
         end
      end
   end

   assign Counter_Out = r_count;
   assign running     = r_running;
   assign tc_pulse    = r_tc;
   assign blow_up     = r_blow;

endmodule

// File: tb/tb_nbit_run_counter.sv
// ----------------------------------------------------------------------------
// tb_nbit_run_counter
//
// Three counter instances share the clock, reset and control inputs:
//   DUT 0 : WIDTH=4, PRESCALE=1, WRAP=1
//   DUT 1 : WIDTH=4, PRESCALE=1, WRAP=0
//   DUT 2 : WIDTH=8, PRESCALE=3, WRAP=1
// Each test resets all of them and checks only the instance it targets.
// Expected outputs are queued as each cycle's stimulus is applied and
// popped and compared once the clock edge has produced the outputs.
// ----------------------------------------------------------------------------
module tb_nbit_run_counter;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       up_down = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_value = '0;
   logic [7:0] limit = '0;
   logic       clear_flag = 1'b0;

   logic [3:0] a_cnt, h_cnt;
   logic [7:0] p_cnt;
   logic       a_run, a_tc, a_blow;
   logic       h_run, h_tc, h_blow;
   logic       p_run, p_tc, p_blow;

   always #5 Clock = ~Clock;

   nbit_run_counter #(.WIDTH(4), .PRESCALE(1), .WRAP(1)) u_a (
      .Clock(Clock), .Reset(Reset), .start(start), .stop(stop),
      .up_down(up_down), .load(load), .load_value(load_value[3:0]),
      .limit(limit[3:0]), .clear_flag(clear_flag), .Counter_Out(a_cnt),
      .running(a_run), .tc_pulse(a_tc), .blow_up(a_blow)
   );

   nbit_run_counter #(.WIDTH(4), .PRESCALE(1), .WRAP(0)) u_h (
      .Clock(Clock), .Reset(Reset), .start(start), .stop(stop),
      .up_down(up_down), .load(load), .load_value(load_value[3:0]),
      .limit(limit[3:0]), .clear_flag(clear_flag), .Counter_Out(h_cnt),
      .running(h_run), .tc_pulse(h_tc), .blow_up(h_blow)
   );

   nbit_run_counter #(.WIDTH(8), .PRESCALE(3), .WRAP(1)) u_p (
      .Clock(Clock), .Reset(Reset), .start(start), .stop(stop),
      .up_down(up_down), .load(load), .load_value(load_value),
      .limit(limit), .clear_flag(clear_flag), .Counter_Out(p_cnt),
      .running(p_run), .tc_pulse(p_tc), .blow_up(p_blow)
   );

   typedef struct {
      int sel;
      int cnt;
      int run;
      int tc;
      int blow;
   } exp_t;

   exp_t  sb[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    n_txn = 0;
   string test_name = "init";

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s.%s : got %0d, expected %0d", test_name, tag, obs, exp);
      end
   endtask

   task automatic get_outs(input int sel, output int c, output int r,
                           output int t, output int b);
      case (sel)
         0:       begin c = int'(a_cnt); r = int'(a_run); t = int'(a_tc); b = int'(a_blow); end
         1:       begin c = int'(h_cnt); r = int'(h_run); t = int'(h_tc); b = int'(h_blow); end
         default: begin c = int'(p_cnt); r = int'(p_run); t = int'(p_tc); b = int'(p_blow); end
      endcase
   endtask

   // One clock transaction: inputs already set by the caller, expected
   // post-edge outputs queued, then compared after the edge.
   task automatic tick(input int sel, input int c, input int r, input int t, input int b);
      exp_t e;
      int oc, orr, ot, ob;
      e.sel = sel; e.cnt = c; e.run = r; e.tc = t; e.blow = b;
      sb.push_back(e);
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      get_outs(e.sel, oc, orr, ot, ob);
      n_txn++;
      $display("[%0t] %s dut%0d st=%0d sp=%0d ld=%0d ud=%0d cl=%0d -> cnt=%0d run=%0d tc=%0d blow=%0d",
               $time, test_name, e.sel, start, stop, load, up_down, clear_flag, oc, orr, ot, ob);
      check_val("count",   oc,  e.cnt);
      check_val("running", orr, e.run);
      check_val("tc",      ot,  e.tc);
      check_val("blow_up", ob,  e.blow);
      start = 1'b0; stop = 1'b0; load = 1'b0; clear_flag = 1'b0;
   endtask

   // Asynchronous reset pulse placed between edges; outputs are checked
   // while reset is still high, before any clock edge can occur.
   task automatic pulse_reset(input int sel);
      int oc, orr, ot, ob;
      Reset = 1'b1;
      #1;
      get_outs(sel, oc, orr, ot, ob);
      check_val("rst_count",   oc,  0);
      check_val("rst_running", orr, 0);
      check_val("rst_tc",      ot,  0);
      check_val("rst_blow_up", ob,  0);
      Reset = 1'b0;
   endtask

   initial begin
      // Power-on reset held over the first edge.
      @(posedge Clock);
      #1;
      pulse_reset(0);

      // 1: basic up-count with wrap
      test_name = "up_wrap";
      limit = 8'd15; up_down = 1'b1;
      start = 1'b1; tick(0, 0, 1, 0, 0);
      for (int i = 1; i <= 15; i++) tick(0, i, 1, 0, 0);
      tick(0, 0, 1, 1, 1);
      tick(0, 1, 1, 0, 1);

      // 2: mid-count reset clears count and flag at once, then pause/resume
      test_name = "pause";
      pulse_reset(0);
      start = 1'b1; tick(0, 0, 1, 0, 0);
      for (int i = 1; i <= 6; i++) tick(0, i, 1, 0, 0);
      stop = 1'b1; tick(0, 6, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick(0, 6, 0, 0, 0);
      start = 1'b1; tick(0, 6, 1, 0, 0);
      for (int i = 7; i <= 9; i++) tick(0, i, 1, 0, 0);

      // 3: down-count with halt
      test_name = "down_halt";
      pulse_reset(1);
      up_down = 1'b0;
      load = 1'b1; load_value = 8'd3; tick(1, 3, 0, 0, 0);
      start = 1'b1; tick(1, 3, 1, 0, 0);
      tick(1, 2, 1, 0, 0);
      tick(1, 1, 1, 0, 0);
      tick(1, 0, 1, 0, 0);
      tick(1, 0, 0, 1, 1);
      tick(1, 0, 0, 0, 1);
      start = 1'b1; tick(1, 0, 0, 0, 1);
      tick(1, 0, 0, 0, 1);
      stop = 1'b1; tick(1, 0, 0, 0, 1);
      start = 1'b1; tick(1, 0, 1, 0, 1);
      tick(1, 0, 0, 1, 1);

      // 4: prescaler of 3 with limit 5
      test_name = "prescale";
      pulse_reset(2);
      up_down = 1'b1; limit = 8'd5;
      start = 1'b1; tick(2, 0, 1, 0, 0);
      for (int s = 1; s <= 5; s++) begin
         tick(2, s - 1, 1, 0, 0);
         tick(2, s - 1, 1, 0, 0);
         tick(2, s, 1, 0, 0);
      end
      tick(2, 5, 1, 0, 0);
      tick(2, 5, 1, 0, 0);
      tick(2, 0, 1, 1, 1);
      tick(2, 0, 1, 0, 1);
      stop = 1'b1; tick(2, 0, 0, 0, 1);
      start = 1'b1; tick(2, 0, 1, 0, 1);
      tick(2, 0, 1, 0, 1);
      tick(2, 0, 1, 0, 1);
      tick(2, 1, 1, 0, 1);

      // 5: priorities and flag handling
      test_name = "prio";
      pulse_reset(0);
      up_down = 1'b1; limit = 8'd15;
      load = 1'b1; stop = 1'b1; start = 1'b1; load_value = 8'd9; tick(0, 9, 0, 0, 0);
      tick(0, 9, 0, 0, 0);
      start = 1'b1; stop = 1'b1; tick(0, 9, 0, 0, 0);
      load = 1'b1; load_value = 8'd14; tick(0, 14, 0, 0, 0);
      start = 1'b1; tick(0, 14, 1, 0, 0);
      tick(0, 15, 1, 0, 0);
      clear_flag = 1'b1; tick(0, 0, 1, 1, 1);
      clear_flag = 1'b1; tick(0, 1, 1, 0, 0);
      // limit of 0: every up step is terminal
      limit = 8'd0;
      tick(0, 0, 1, 1, 1);
      tick(0, 0, 1, 1, 1);
      // down-count wraps from 0 to limit
      up_down = 1'b0; limit = 8'd7;
      tick(0, 7, 1, 1, 1);
      tick(0, 6, 1, 0, 1);
      // load while running returns to IDLE with no pulse
      load = 1'b1; load_value = 8'd2; tick(0, 2, 0, 0, 1);

      // 6: out-of-range load on the 8-bit instance
      test_name = "oor_load";
      pulse_reset(2);
      up_down = 1'b1; limit = 8'd10;
      load = 1'b1; load_value = 8'd200; tick(2, 200, 0, 0, 0);
      start = 1'b1; tick(2, 200, 1, 0, 0);
      tick(2, 200, 1, 0, 0);
      tick(2, 200, 1, 0, 0);
      tick(2, 0, 1, 1, 1);
      tick(2, 0, 1, 0, 1);

      if (sb.size() != 0) check_val("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
